// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command-frame parser: FSM state encodings,
// default start-of-frame byte and frame field offsets.
package uart_cmd_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_LEN    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  // Byte offsets of the fixed frame fields; payload starts at OFS_DATA.
  localparam int OFS_SOF  = 0;
  localparam int OFS_ADDR = 1;
  localparam int OFS_LEN  = 2;
  localparam int OFS_DATA = 3;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write bus of the UART command parser.
// master: the parser side; slave: the byte source / bus consumer side.
interface uart_cmd_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       WR_EN;
  logic [7:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  logic       BUSY;

  modport master (
    input  RX_DATA, RX_VALID,
    output WR_EN, WR_ADDR, WR_DATA, FRAME_OK, FRAME_ERR, BUSY
  );

  modport slave (
    output RX_DATA, RX_VALID,
    input  WR_EN, WR_ADDR, WR_DATA, FRAME_OK, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/uart_cmd_buf.sv
// Payload buffer: MAX_LEN x 8 flops, one write port, combinational read port.
// Index values at or beyond MAX_LEN read as zero and never write.
module uart_cmd_buf #(
  parameter int MAX_LEN = 16,
  parameter int IW      = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] ridx,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  // Store one payload byte at widx.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (we && (widx == IW'(i))) mem[i] <= wdata;
    end
  end

  // Read mux over all entries.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (ridx == IW'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame decoder and register-write sequencer.
// Frame: SOF ADDR LEN DATA[0..LEN-1] CSUM, CSUM = XOR of ADDR, LEN and DATA.
// Writes are issued only after the checksum matches.
// Optional macro UART_CMD_TIMEOUT_EN adds an inter-byte timeout of TIMEOUT_CYC.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for SOF, other bytes ignored
// ST_ADDR   | expecting start address, seeds checksum
// ST_LEN    | expecting payload length, range checked
// ST_DATA   | collecting payload into buffer
// ST_CSUM   | expecting checksum byte
// ST_COMMIT | issuing LEN writes, then FRAME_OK
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = 16
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 50000
`endif
) (
  input logic        CLK,
  input logic        RESET,
  uart_cmd_if.master bus
);

  localparam int IW = $clog2(MAX_LEN + 1);

  logic [2:0]    state;
  logic [7:0]    csum;
  logic [7:0]    start_addr;
  logic [IW-1:0] idx;
  logic [IW-1:0] len_q;
  logic [7:0]    buf_rdata;
  logic          buf_we;
  logic          len_bad;
  logic          timeout;
  logic          wr_en_q, frame_ok_q, frame_err_q;
  logic [7:0]    wr_addr_q, wr_data_q;

  assign buf_we  = (state == ST_DATA) && bus.RX_VALID;
  assign len_bad = (bus.RX_DATA == 8'd0) || (bus.RX_DATA > 8'(MAX_LEN));

  uart_cmd_buf #(.MAX_LEN(MAX_LEN), .IW(IW)) u_buf (
    .CLK   (CLK),
    .we    (buf_we),
    .widx  (idx),
    .wdata (bus.RX_DATA),
    .ridx  (idx),
    .rdata (buf_rdata)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] timer;
  logic          in_frame;

  assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CSUM);
  assign timeout  = in_frame && (timer == TW'(TIMEOUT_CYC - 1));

  // Inter-byte timer: restarts on every byte, idle outside the receive states.
  always_ff @(posedge CLK) begin
    if (RESET || !in_frame || bus.RX_VALID) timer <= '0;
    else                                    timer <= timer + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame FSM, checksum, address counter and output strobes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      csum        <= '0;
      start_addr  <= '0;
      idx         <= '0;
      len_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (timeout && !bus.RX_VALID) begin
        frame_err_q <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.RX_VALID && (bus.RX_DATA == SOF)) state <= ST_ADDR;
          end
          ST_ADDR: begin
            if (bus.RX_VALID) begin
              start_addr <= bus.RX_DATA;
              csum       <= bus.RX_DATA;
              state      <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (bus.RX_VALID) begin
              if (len_bad) begin
                frame_err_q <= 1'b1;
                state       <= ST_IDLE;
              end else begin
                len_q <= IW'(bus.RX_DATA);
                csum  <= csum ^ bus.RX_DATA;
                idx   <= '0;
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (bus.RX_VALID) begin
              csum <= csum ^ bus.RX_DATA;
              if (idx == len_q - IW'(1)) begin
                idx   <= '0;
                state <= ST_CSUM;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
          ST_CSUM: begin
            if (bus.RX_VALID) begin
              if (bus.RX_DATA == csum) begin
                // First write leaves on the cycle right after the checksum byte.
                wr_en_q   <= 1'b1;
                wr_addr_q <= start_addr;
                wr_data_q <= buf_rdata;
                idx       <= IW'(1);
                state     <= ST_COMMIT;
              end else begin
                frame_err_q <= 1'b1;
                state       <= ST_IDLE;
              end
            end
          end
          ST_COMMIT: begin
            if (idx < len_q) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_addr_q + 8'd1;
              wr_data_q <= buf_rdata;
              idx       <= idx + IW'(1);
            end else begin
              frame_ok_q <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.WR_EN     = wr_en_q;
  assign bus.WR_ADDR   = wr_addr_q;
  assign bus.WR_DATA   = wr_data_q;
  assign bus.FRAME_OK  = frame_ok_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.BUSY      = (state != ST_IDLE);

endmodule
